// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave that turns each accepted transfer into one APB3 transfer,
// with PREADY wait-state extension, PSLVERR-to-ERROR mapping and an optional PREADY timeout.
module ahbl_apb_bridge #(
  parameter int TIMEOUT  = 0,
  parameter int TO_WIDTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TO_WIDTH-1:0] CNT_MAX = {TO_WIDTH{1'b1}};

  state_e              state_q, state_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                hreadyout_q, hresp_q, psel_q, penable_q, pwrite_q;
  logic [31:0]         hrdata_q, paddr_q;
  logic                accept_s, load_rdata_s, unused_htrans_s;

  assign accept_s        = HSEL & HTRANS[1] & HREADYIN & hreadyout_q;
  assign unused_htrans_s = HTRANS[0];

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = HWDATA;

  // Next-state, timeout counter and read-data capture decisions
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_rdata_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept_s) begin
          state_d = ST_SETUP;
          cnt_d   = {TO_WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_d = ST_ERR1;
          end else begin
            state_d      = ST_DONE;
            load_rdata_s = ~pwrite_q;
          end
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
          // cnt_q counts completed low-PREADY cycles, so this cycle is number TIMEOUT
          if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {TO_WIDTH{1'b0}};
      end
    endcase
  end

  // FSM state plus registered bus outputs decoded from the next state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {TO_WIDTH{1'b0}};
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'h0000_0000;
      paddr_q     <= 32'h0000_0000;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q   <= (state_d == ST_ACCESS);
      hreadyout_q <= (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
      if (accept_s) begin
        paddr_q  <= HADDR;
        pwrite_q <= HWRITE;
      end
      if (load_rdata_s) begin
        hrdata_q <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed bench for ahbl_apb_bridge: acts as AHB master and APB slave, scoreboard of
// expected completions (response, read data, data-phase length, PSEL length).
module tb_ahbl_apb_bridge;
  localparam int TIMEOUT = 4;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADYIN, PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA, PRDATA;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP, PSEL, PENABLE, PWRITE;
  logic [31:0] HRDATA, PADDR, PWDATA;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          ncyc;
    int          npsel;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_hrdata = 32'h0;

  ahbl_apb_bridge #(.TIMEOUT(TIMEOUT), .TO_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    repeat (n) tick();
  endtask

  // One AHB transfer; address phase is driven in the current cycle, so chained calls are back-to-back
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int nwait, input logic slverr, input logic [31:0] prdata);
    exp_t e;
    logic to;
    int   cycles, npsel, nerr1, acc;
    to     = (nwait >= TIMEOUT);
    e.resp = slverr | to;
    if (!wr && !e.resp) model_hrdata = prdata;
    e.rdata = model_hrdata;
    e.ncyc  = to ? TIMEOUT + 3 : (slverr ? nwait + 4 : nwait + 3);
    e.npsel = to ? TIMEOUT + 1 : nwait + 2;
    sb_q.push_back(e);

    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HWDATA = wdata;
    cycles = 1; npsel = 0; nerr1 = 0; acc = 0;
    while (HREADYOUT !== 1'b1 && cycles < 40) begin
      check("penable_without_psel", {31'd0, PENABLE & ~PSEL}, 32'd0);
      if (PSEL === 1'b1) npsel++;
      if (HRESP === 1'b1) nerr1++;
      if (PENABLE === 1'b1) begin
        acc++;
        if (acc == 1) begin
          check("paddr", PADDR, addr);
          check("pwrite", {31'd0, PWRITE}, {31'd0, wr});
          if (wr) check("pwdata", PWDATA, wdata);
        end
        PREADY  = (acc > nwait);
        PSLVERR = slverr & PREADY;
        PRDATA  = PREADY ? prdata : ~prdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
      end
      tick();
      cycles++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;

    check("sb_not_empty", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("data_phase_cycles", 32'(cycles), 32'(e.ncyc));
      check("psel_cycles", 32'(npsel), 32'(e.npsel));
      check("hresp_first_err_cycle", 32'(nerr1), e.resp ? 32'd1 : 32'd0);
      check("hresp_final", {31'd0, HRESP}, {31'd0, e.resp});
      check("hrdata", HRDATA, e.rdata);
      check("psel_at_completion", {31'd0, PSEL}, 32'd0);
    end
  endtask

  logic [1:0] tr_tab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       sel_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic       rdy_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = 32'h0; HREADYIN = 1'b1; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) tick();
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hresp", {31'd0, HRESP}, 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_psel_penable_pwrite", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
    HRESET = 1'b0;
    tick();

    xfer(1'b1, 32'h0000_0010, 32'hA5A5_1234, 0, 1'b0, 32'h0);
    idle(2);
    xfer(1'b0, 32'h0000_0014, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
    xfer(1'b1, 32'h0000_0018, 32'h1357_9BDF, 1, 1'b1, 32'h0);
    xfer(1'b0, 32'h0000_001C, 32'h0, 0, 1'b1, 32'h1111_1111);
    idle(1);
    xfer(1'b0, 32'h0000_0100, 32'h0, 100, 1'b0, 32'h2222_2222);
    xfer(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
    idle(1);
    xfer(1'b1, 32'h0000_0020, 32'h0000_55AA, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h0000_0024, 32'h0, 2, 1'b0, 32'hCAFE_0001);

    for (int i = 0; i < 4; i++) begin
      HSEL = sel_tab[i]; HTRANS = tr_tab[i]; HREADYIN = rdy_tab[i]; HADDR = 32'h0000_0080;
      tick();
      check("noaccept_psel", {31'd0, PSEL}, 32'd0);
      check("noaccept_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("noaccept_hresp", {31'd0, HRESP}, 32'd0);
    end
    HREADYIN = 1'b1;

    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0040; HWRITE = 1'b0;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    check("rstmid_setup_psel", {30'd0, PSEL, PENABLE}, 32'd2);
    tick();
    check("rstmid_access_psel", {30'd0, PSEL, PENABLE}, 32'd3);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("rstmid_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
    check("rstmid_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rstmid_hresp", {31'd0, HRESP}, 32'd0);
    check("rstmid_hrdata", HRDATA, 32'h0);
    model_hrdata = 32'h0;
    xfer(1'b0, 32'h0000_0030, 32'h0, 1, 1'b0, 32'h600D_600D);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
